// File: rtl/awg_pkg.sv
// Shared constants and FSM encoding for the AWG sweep controller.
package awg_pkg;

  localparam int unsigned FW_W_DEFAULT    = 20;
  localparam int unsigned DWELL_W_DEFAULT = 24;
  localparam int unsigned SIN_PTS         = 256;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_LIN = 2'b01;
  localparam logic [1:0] MODE_SIN = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDwell,
    StLinStep,
    StSinReq,
    StSinCalc
  } state_e;

endpackage

// File: rtl/sweep_sine_lut.sv
// Sine LUT: s = round(127.5 * (1 + sin(2*pi*idx/256))), quarter-wave ROM with quadrant fold,
// one cycle registered latency.
module sweep_sine_lut (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] idx,
  output logic [7:0] s
);

  localparam logic [7:0] QTR [64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
    8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
  };

  logic [6:0] addr;
  logic [7:0] mag;
  logic [7:0] s_d;

  // Odd quadrants mirror (64 - k); address 64 is the peak, which the ROM does not hold.
  // The lower half is 255 - upper, except idx 128 where the rounding tie breaks symmetry.
  always_comb begin
    addr = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag  = addr[6] ? 8'd255 : QTR[addr[5:0]];
    if (idx == 8'd128) begin
      s_d = 8'd128;
    end else begin
      s_d = idx[7] ? ~mag : mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= s_d;
    end
  end

endmodule

// File: rtl/awg_sweep_controller.sv
// Frequency-word sequencer for the AWG: base passthrough, triangle or sinusoidal sweep.
// Define AWG_SWEEP_MARKER_EN to enable the endpoint marker pulse.
module awg_sweep_controller
  import awg_pkg::*;
#(
  parameter int unsigned FW_W    = FW_W_DEFAULT,
  parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg_mode,
  input  logic [FW_W-1:0]    base_freq,
  input  logic [FW_W-1:0]    f_lo,
  input  logic [FW_W-1:0]    f_hi,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FW_W-1:0]    freq_word,
  output logic               freq_update,
  output logic               sweep_active,
  output logic               sweep_dir,
  output logic               marker
);

  localparam int unsigned IDX_W = $clog2(SIN_PTS);
  localparam logic [DWELL_W-1:0] CntOne = 1;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [FW_W-1:0]    freq_q, freq_d;
  logic               upd_q, upd_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         lut_s;

  logic mode_chg, is_lin, is_sin, degen;
  logic [DWELL_W-1:0] dwell_ld;

  assign mode_chg = (cfg_mode != mode_q);
  assign is_lin   = (mode_q == MODE_LIN);
  assign is_sin   = (mode_q == MODE_SIN);
  assign degen    = (f_lo >= f_hi);
  assign dwell_ld = (dwell == '0) ? CntOne : dwell;

  sweep_sine_lut u_lut (
    .clk (clk),
    .rst (rst),
    .idx (idx_q),
    .s   (lut_s)
  );

  // Linear step, computed one bit wider so large steps cannot wrap.
  logic [FW_W-1:0] f_clamp, lin_f;
  logic [FW_W:0]   sum_up, lo_plus;
  logic            lin_hit_hi, lin_hit_lo, lin_dir;

  always_comb begin
    f_clamp = freq_q;
    if (freq_q < f_lo) begin
      f_clamp = f_lo;
    end else if (freq_q > f_hi) begin
      f_clamp = f_hi;
    end
    sum_up     = {1'b0, f_clamp} + {1'b0, f_step};
    lo_plus    = {1'b0, f_lo} + {1'b0, f_step};
    lin_hit_hi = (sum_up >= {1'b0, f_hi});
    lin_hit_lo = ({1'b0, f_clamp} <= lo_plus);
    if (!dir_q) begin
      lin_f   = lin_hit_hi ? f_hi : sum_up[FW_W-1:0];
      lin_dir = lin_hit_hi;
    end else begin
      lin_f   = lin_hit_lo ? f_lo : (f_clamp - f_step);
      lin_dir = !lin_hit_lo;
    end
  end

  // Sinusoidal point: f_lo + ((f_hi - f_lo) * s) >> 8.
  logic [FW_W-1:0]   span, sin_f;
  logic [FW_W+7:0]   prod;
  logic              unused_frac;

  assign span        = f_hi - f_lo;
  assign prod        = {8'b0, span} * {{FW_W{1'b0}}, lut_s};
  assign sin_f       = f_lo + prod[FW_W+7:8];
  assign unused_frac = ^prod[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_chg) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StLoad:    state_d = is_lin ? StDwell : (is_sin ? StSinReq : StIdle);
        StDwell:   if (cnt_q <= CntOne) state_d = is_sin ? StSinReq : StLinStep;
        StLinStep: state_d = StDwell;
        StSinReq:  state_d = StSinCalc;
        StSinCalc: state_d = StDwell;
        default:   state_d = StIdle;
      endcase
    end
  end

  // A mode change freezes the datapath for one cycle; LOAD then restarts cleanly.
  always_comb begin
    freq_d = freq_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (!mode_chg) begin
      unique case (state_q)
        StIdle: freq_d = base_freq;
        StLoad: begin
          dir_d = 1'b0;
          idx_d = '0;
          if (is_lin) begin
            freq_d = f_lo;
            cnt_d  = dwell_ld;
          end
        end
        StDwell: cnt_d = cnt_q - CntOne;
        StLinStep: begin
          cnt_d = dwell_ld;
          if (degen) begin
            freq_d = f_lo;
          end else if (f_step != '0) begin
            freq_d = lin_f;
            dir_d  = lin_dir;
          end
        end
        StSinReq: ;
        StSinCalc: begin
          cnt_d  = dwell_ld;
          idx_d  = idx_q + 8'd1;
          freq_d = degen ? f_lo : sin_f;
        end
        default: ;
      endcase
    end
    upd_d = (freq_d != freq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      freq_q <= '0;
      upd_q  <= 1'b0;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      mode_q <= cfg_mode;
      freq_q <= freq_d;
      upd_q  <= upd_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  assign freq_word    = freq_q;
  assign freq_update  = upd_q;
  assign sweep_active = is_lin | is_sin;
  assign sweep_dir    = dir_q & is_lin;

`ifdef AWG_SWEEP_MARKER_EN
  logic mark_d, mark_q;

  always_comb begin
    mark_d = 1'b0;
    if (!mode_chg && !degen && upd_d) begin
      if (state_q == StLinStep && f_step != '0 && !dir_q && lin_hit_hi) mark_d = 1'b1;
      if (state_q == StSinCalc && idx_q == '1) mark_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_q <= 1'b0;
    end else begin
      mark_q <= mark_d;
    end
  end

  assign marker = mark_q;
`else
  assign marker = 1'b0;
`endif

endmodule

// File: tb/tb_awg_sweep_controller.sv
// Scoreboard bench for awg_sweep_controller: stimulus pushes expected frequency words,
// a monitor pops and compares on every freq_update.
module tb_awg_sweep_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'b00;
  logic [19:0] base_freq = '0;
  logic [19:0] f_lo = '0;
  logic [19:0] f_hi = '0;
  logic [19:0] f_step = '0;
  logic [23:0] dwell = '0;
  logic [19:0] freq_word;
  logic        freq_update, sweep_active, sweep_dir, marker;

  awg_sweep_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode     (cfg_mode),
    .base_freq    (base_freq),
    .f_lo         (f_lo),
    .f_hi         (f_hi),
    .f_step       (f_step),
    .dwell        (dwell),
    .freq_word    (freq_word),
    .freq_update  (freq_update),
    .sweep_active (sweep_active),
    .sweep_dir    (sweep_dir),
    .marker       (marker)
  );

  always #5 clk = ~clk;

  // gap: cycles since previous update (0 = don't care); dir: -1 = don't care
  typedef struct {
    int f;
    int gap;
    int dir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   marks = 0;
  int   exp_marks = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic push(int f, int gap, int dir);
    exp_t e;
    e.f = f;
    e.gap = gap;
    e.dir = dir;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(int max_cyc, string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout_pending"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int sin_s(int k);
    real x;
    x = 127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * k / 256.0);
    return $rtoi(x + 0.5);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (marker) marks++;
      if (freq_update) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_update: freq_word=%0d, expected no update (t=%0t)",
                   freq_word, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("freq_word", int'(freq_word), mon_e.f);
          if (mon_e.gap > 0) check("hold_cycles", cyc, mon_e.gap);
          if (mon_e.dir >= 0) check("sweep_dir", int'(sweep_dir), mon_e.dir);
        end
        cyc = 0;
      end
    end
  end

  initial begin
    int last_f;
    int run;
    int s;
    // Reset state
    #1;
    check("rst_freq_word", int'(freq_word), 0);
    check("rst_freq_update", int'(freq_update), 0);
    check("rst_sweep_active", int'(sweep_active), 0);
    check("rst_sweep_dir", int'(sweep_dir), 0);
    check("rst_marker", int'(marker), 0);
    step(3);
    mon_en = 1'b1;
    rst = 1'b0;
    step(3);

    // Off mode passthrough, single pulse
    base_freq = 20'd100000;
    push(100000, 0, -1);
    wait_drain(10, "off");
    step(10);
    check("off_active", int'(sweep_active), 0);

    // Linear triangle sweep
    f_lo = 20'd1000; f_hi = 20'd1500; f_step = 20'd200; dwell = 24'd4;
    cfg_mode = 2'b01;
    push(1000, 0, 0); push(1200, 5, 0); push(1400, 5, 0); push(1500, 5, 1);
    push(1300, 5, 1); push(1100, 5, 1); push(1000, 5, 0); push(1200, 5, 0);
    push(1400, 5, 0); push(1500, 5, 1);
    exp_marks += 2;
    wait_drain(100, "lin");
    check("lin_active", int'(sweep_active), 1);

    // Mode change lin->sin mid-dwell, then sinusoidal sweep through one wrap
    step(1);
    f_lo = 20'd0; f_hi = 20'd25600; dwell = 24'd1;
    cfg_mode = 2'b10;
    step(1);
    check("switch_dir_cleared", int'(sweep_dir), 0);
    check("switch_active", int'(sweep_active), 1);
    last_f = -1;
    run = 0;
    for (int k = 0; k <= 256; k++) begin
      s = sin_s(k % 256);
      run++;
      if (100 * s != last_f) begin
        push(100 * s, (k == 0) ? 0 : 3 * run, -1);
        last_f = 100 * s;
        run = 0;
      end
    end
    exp_marks += 1;
    wait_drain(1200, "sin");

    // Degenerate bounds, linear then sinusoidal: constant 5000
    step(1);
    f_lo = 20'd5000; f_hi = 20'd5000; f_step = 20'd200; dwell = 24'd2;
    cfg_mode = 2'b01;
    push(5000, 0, 0);
    wait_drain(20, "degen_lin");
    step(30);
    cfg_mode = 2'b10;
    step(40);
    check("degen_sin_freq", int'(freq_word), 5000);

    // Full-scale step: saturates at hi and lo without wrap
    f_lo = 20'd16; f_hi = 20'hFFFFF; f_step = 20'hFFFFF; dwell = 24'd2;
    cfg_mode = 2'b01;
    push(16, 0, 0); push('hFFFFF, 3, 1); push(16, 3, 0); push('hFFFFF, 3, 1); push(16, 3, 0);
    exp_marks += 2;
    wait_drain(100, "fullscale");

    // New bounds mid-sweep: 16 clamps to 1000, steps to 3000
    step(1);
    f_lo = 20'd1000; f_hi = 20'd5000; f_step = 20'd2000; dwell = 24'd3;
    push(3000, 3, 0);
    wait_drain(20, "clamp");

    // Asynchronous reset mid-sweep
    #2;
    check("pre_rst_freq", int'(freq_word), 3000);
    rst = 1'b1;
    #1;
    check("async_rst_freq_word", int'(freq_word), 0);
    check("async_rst_update", int'(freq_update), 0);
    check("async_rst_active", int'(sweep_active), 0);
    check("async_rst_dir", int'(sweep_dir), 0);
    check("async_rst_marker", int'(marker), 0);
    cfg_mode = 2'b00;
    base_freq = 20'd777;
    step(2);
    push(777, 0, -1);
    rst = 1'b0;
    wait_drain(10, "post_rst_idle");
    step(5);
    check("post_rst_active", int'(sweep_active), 0);

    check("queue_empty", exp_q.size(), 0);
`ifdef AWG_SWEEP_MARKER_EN
    check("marker_count", marks, exp_marks);
`else
    check("marker_count", marks, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
